// File: rtl/ones_count_frame_decoder.sv
// ones_count_frame_decoder: buffers 2-bit ones counts in a FIFO and replays each one
// as a serial 3-bit thermometer frame (a, b, c) over a valid/ready output.
module ones_count_frame_decoder #(
    parameter int DEPTH    = 4,
    parameter int IDLE_GAP = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             cnt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_bit,
    output logic                   out_sof,
    output logic [7:0]             frame_cnt,
    output logic [$clog2(DEPTH):0] fifo_lvl
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [3:0] GAP_LOAD = 4'(IDLE_GAP > 0 ? IDLE_GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t      state;
    logic [1:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [2:0]  shreg;
    logic [1:0]  bit_idx;
    logic [3:0]  gap_cnt;
    logic [1:0]  head;
    logic        empty, push, pop, last_beat;

    assign fifo_lvl  = wr_ptr - rd_ptr;
    assign empty     = fifo_lvl == '0;
    assign in_ready  = fifo_lvl != FULL;
    assign push      = in_valid & in_ready;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign last_beat = state == SHIFT && out_ready && bit_idx == 2'd2;
    // The final GAP cycle doubles as IDLE so the gap is exactly IDLE_GAP cycles long
    assign pop = !empty && (state == IDLE || (last_beat && IDLE_GAP == 0) ||
                            (state == GAP && gap_cnt == 4'd0));

    assign out_valid = state == SHIFT;
    assign out_bit   = out_valid & shreg[bit_idx];
    assign out_sof   = out_valid & (bit_idx == 2'd0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            shreg     <= '0;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                shreg   <= {head == 2'd3, head[1], head != 2'd0};
                bit_idx <= '0;
            end
            case (state)
                IDLE: if (pop) state <= SHIFT;
                SHIFT: if (out_ready) begin
                    if (bit_idx != 2'd2) bit_idx <= bit_idx + 1'b1;
                    else begin
                        frame_cnt <= frame_cnt + 1'b1;
                        if (IDLE_GAP > 0) begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end else if (!pop) state <= IDLE;
                    end
                end
                GAP: if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 1'b1;
                     else state <= pop ? SHIFT : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ones_count_frame_decoder.sv
// tb_ones_count_frame_decoder: directed table/sequence tests plus a random run checked
// against a queue-based model of the expected serial bit stream.
module tb_ones_count_frame_decoder;
    localparam int DEPTH = 4;

    typedef struct {
        logic [1:0] k;
        logic [2:0] frame;
    } vec_t;

    logic       clk = 0, rst = 0, in_valid = 0, out_ready = 0;
    logic [1:0] cnt = 0;
    logic       in_ready, out_valid, out_bit, out_sof;
    logic [7:0] frame_cnt;
    logic [2:0] fifo_lvl;
    logic       in_ready2, out_valid2, out_bit2, out_sof2;
    logic [7:0] frame_cnt2;
    logic [2:0] fifo_lvl2;

    int tests = 0, fails = 0;
    bit exp_q[$];
    int beats = 0, pushes = 0;

    ones_count_frame_decoder #(.DEPTH(DEPTH), .IDLE_GAP(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cnt(cnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_sof(out_sof),
        .frame_cnt(frame_cnt), .fifo_lvl(fifo_lvl));

    ones_count_frame_decoder #(.DEPTH(DEPTH), .IDLE_GAP(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .cnt(cnt),
        .out_valid(out_valid2), .out_ready(out_ready), .out_bit(out_bit2), .out_sof(out_sof2),
        .frame_cnt(frame_cnt2), .fifo_lvl(fifo_lvl2));

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic push(input logic [1:0] k);
        int w = 0;
        in_valid = 1;
        cnt = k;
        while (!in_ready && w < 200) begin
            tick();
            w++;
        end
        if (w >= 200) timeout("push");
        tick();
        in_valid = 0;
    endtask

    task automatic drain();
        int w = 0;
        in_valid = 0;
        out_ready = 1;
        while ((out_valid || fifo_lvl != 0) && w < 200) begin
            tick();
            w++;
        end
        if (w >= 200) timeout("drain");
    endtask

    // Reference model: every accepted count appends its thermometer frame to a bit queue;
    // occupancy is pushes minus frames already taken out of the FIFO.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            beats = 0;
            pushes = 0;
        end else begin
            int popped, lvl;
            bit rdy;
            popped = (beats + 2) / 3 + ((out_valid && beats % 3 == 0) ? 1 : 0);
            lvl = pushes - popped;
            rdy = lvl < DEPTH;
            check("m_frame_cnt", frame_cnt, (beats / 3) % 256);
            check("m_fifo_lvl", fifo_lvl, lvl);
            check("m_in_ready", in_ready, rdy);
            if (!out_valid) check("m_idle_zero", {out_bit, out_sof}, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) timeout("m_spurious_bit");
                else begin
                    check("m_bit", out_bit, exp_q.pop_front());
                    check("m_sof", out_sof, beats % 3 == 0);
                end
                beats++;
            end
            if (in_valid && rdy) begin
                exp_q.push_back(cnt >= 1);
                exp_q.push_back(cnt >= 2);
                exp_q.push_back(cnt == 3);
                pushes++;
            end
        end
    end

    initial begin
        vec_t tbl[4];
        logic [11:0] stream;
        logic v_s[16], b_s[16];
        logic [13:0] v_exp, b_exp;
        logic [5:0] pat;
        int f, w, beats4;
        logic prev_sof;

        tbl[0] = '{k: 2'd0, frame: 3'b000};
        tbl[1] = '{k: 2'd1, frame: 3'b100};
        tbl[2] = '{k: 2'd2, frame: 3'b110};
        tbl[3] = '{k: 2'd3, frame: 3'b111};

        #1 rst = 1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_fifo_lvl", fifo_lvl, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_bit_sof", {out_bit, out_sof}, 0);
        tick();
        tick();
        rst = 0;

        // Single frames: latency, bit order, sof placement, frame count
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            push(tbl[i].k);
            check("lat_pre", out_valid, 0);
            tick();
            check("lat_rise", out_valid, 1);
            for (int j = 0; j < 3; j++) begin
                check("t1_valid", out_valid, 1);
                check("t1_bit", out_bit, tbl[i].frame[2-j]);
                check("t1_sof", out_sof, j == 0);
                tick();
            end
            check("t1_frame_cnt", frame_cnt, i + 1);
            check("t1_idle", out_valid, 0);
        end

        // Back-to-back 0,1,2,3: 12 contiguous beats
        for (int j = 0; j < 12; j++) stream[11-j] = tbl[j/3].frame[2-(j%3)];
        for (int c = 0; c < 16; c++) begin
            in_valid = c < 4;
            cnt = tbl[c % 4].k;
            v_s[c] = out_valid;
            b_s[c] = out_bit;
            tick();
        end
        in_valid = 0;
        f = 16;
        for (int c = 15; c >= 0; c--) if (v_s[c]) f = c;
        check("t2_first", f, 2);
        if (f <= 2) begin
            for (int j = 0; j < 12; j++) begin
                check("t2_valid", v_s[f+j], 1);
                check("t2_bit", b_s[f+j], stream[11-j]);
            end
            check("t2_end", v_s[f+12], 0);
        end
        check("t2_frame_cnt", frame_cnt, 8);

        // Full FIFO behind a stalled frame
        do_reset();
        out_ready = 0;
        push(3);
        tick();
        check("t3_shift", out_valid, 1);
        for (int i = 0; i < 4; i++) begin
            check("t3_ready", in_ready, 1);
            push(2'(i));
        end
        check("t3_lvl_full", fifo_lvl, 4);
        check("t3_not_ready", in_ready, 0);
        in_valid = 1;
        cnt = 2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_held_ready", in_ready, 0);
            check("t3_held_lvl", fifo_lvl, 4);
        end
        out_ready = 1;
        w = 0;
        while (!in_ready && w < 10) begin
            tick();
            w++;
        end
        check("t3_pop_wait", w, 3);
        tick();
        in_valid = 0;
        check("t3_lvl_after", fifo_lvl, 4);
        drain();

        // Frame 111 with stalls
        do_reset();
        out_ready = 0;
        push(3);
        w = 0;
        while (!out_valid && w < 10) begin
            tick();
            w++;
        end
        check("t4_valid_wait", w, 1);
        pat = 6'b101001;
        beats4 = 0;
        prev_sof = 0;
        for (int p = 0; p < 6; p++) begin
            out_ready = pat[p];
            check("t4_valid", out_valid, 1);
            check("t4_bit", out_bit, 1);
            if (p > 0 && !pat[p-1]) check("t4_sof_hold", out_sof, prev_sof);
            if (out_valid && out_ready) begin
                check("t4_sof", out_sof, beats4 == 0);
                beats4++;
            end
            prev_sof = out_sof;
            tick();
        end
        check("t4_beats", beats4, 3);
        check("t4_done", out_valid, 0);
        check("t4_frame_cnt", frame_cnt, 1);

        // IDLE_GAP=2 instance: frames 111 and 100 with two idle cycles between
        do_reset();
        out_ready = 1;
        v_exp = 14'b00111001110000;
        b_exp = 14'b00111001000000;
        for (int c = 0; c < 14; c++) begin
            in_valid = c < 2;
            cnt = (c == 0) ? 2'd3 : 2'd1;
            check("t5_valid", out_valid2, v_exp[13-c]);
            check("t5_bit", out_bit2, b_exp[13-c]);
            check("t5_sof", out_sof2, v_exp[13-c] && (c == 2 || c == 7));
            tick();
        end
        in_valid = 0;
        check("t5_frame_cnt", frame_cnt2, 2);
        drain();

        // Reset mid-frame after bit b, two entries still queued
        do_reset();
        out_ready = 1;
        in_valid = 1;
        cnt = 2;
        tick();
        cnt = 1;
        tick();
        cnt = 3;
        tick();
        in_valid = 0;
        tick();
        check("t6_pre_valid", out_valid, 1);
        check("t6_pre_bit_c", out_bit, 0);
        check("t6_pre_lvl", fifo_lvl, 2);
        rst = 1;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_lvl", fifo_lvl, 0);
        check("t6_frame_cnt", frame_cnt, 0);
        check("t6_in_ready", in_ready, 1);
        tick();
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t6_quiet", out_valid, 0);
        end

        // frame_cnt wraps after 256 frames
        for (int i = 0; i < 256; i++) push(2'($urandom_range(0, 3)));
        drain();
        check("wrap_frame_cnt", frame_cnt, 0);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            cnt = 2'($urandom_range(0, 3));
            out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        drain();
        check("rand_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
